// File: rtl/ps2_key_scheduler.sv
// -----------------------------------------------------------------------------
// ps2_key_scheduler
//
// Sits between the hps_io ps2_key bus and the rememotech keyboard inputs
// (key_ready / key_stroke / key_code). Every toggle of ps2_key[10] is captured
// into a small FIFO. The events are then replayed to the core one at a time.
// Consecutive key_ready strobes are separated by at least GAP_CYCLES clocks, so
// a burst of events from the HPS is never lost. This replaces the bare
// toggle-XOR key strobe in the emu top level.
//
// Parameters
//   DEPTH       FIFO entries; must be a power of 2 and at least 2
//   GAP_CYCLES  minimum clk_sys cycles from one key_ready strobe to the next;
//               must be at least 1
//
// Ports
//   clk_sys     in   1     system clock; this is the only clock
//   reset       in   1     synchronous, active-high reset
//   ps2_key     in   11    [10] toggle, [9] pressed, [8] extended, [7:0] scancode
//   flush       in   1     synchronous clear of queued events
//   key_ready   out  1     one-cycle strobe; key_stroke/key_code are valid
//   key_stroke  out  1     1 = break (release), 0 = make (press)
//   key_code    out  10    {1'b0, extended, scancode}
//   fifo_level  out  AW+1  number of entries currently queued
//   overflow    out  1     sticky; set when an event was dropped
//
// Optional feature (macro KEYSCHED_DEDUP_EN)
//   When KEYSCHED_DEDUP_EN is defined, a 512-bit held-key map, indexed by
//   {extended, scancode}, filters typematic repeats at capture time:
//     - a make for a key that is already held is not queued;
//     - a break for a key that is not held is not queued.
//   These dropped duplicates do not set overflow.
//   When KEYSCHED_DEDUP_EN is undefined, every toggle event is queued.
// -----------------------------------------------------------------------------
module ps2_key_scheduler #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 250000
) (
    input  logic                     clk_sys,
    input  logic                     reset,
    input  logic [10:0]              ps2_key,
    input  logic                     flush,
    output logic                     key_ready,
    output logic                     key_stroke,
    output logic [9:0]               key_code,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    // The counter only ever holds GAP_CYCLES-1, so $clog2(GAP_CYCLES) bits
    // are sufficient. The minimum width is 1 bit, for the case GAP_CYCLES == 1.
    localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Capture
    // -------------------------------------------------------------------------
    logic          toggle_hist_reg;
    logic          capture;
    logic [9:0]    entry;
    logic          accept;

    // The history register follows ps2_key[10] on every cycle, including
    // during reset. As a result, a toggle level that is held across reset
    // release does not look like a new event.
    always_ff @(posedge clk_sys) begin
        toggle_hist_reg <= ps2_key[10];
    end

    assign capture = (ps2_key[10] != toggle_hist_reg);
    // Stored form: [9] = break flag, [8:0] = {extended, scancode}.
    assign entry   = {~ps2_key[9], ps2_key[8:0]};

    // -------------------------------------------------------------------------
    // FIFO pointers and status
    // -------------------------------------------------------------------------
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          fifo_empty;
    logic          fifo_full;
    logic          want_push;
    logic          push;
    logic          pop;
    logic          drop;
    logic          overflow_reg;
    state_t        state_reg;

    assign wr_idx     = wr_ptr_reg[AW-1:0];
    assign rd_idx     = rd_ptr_reg[AW-1:0];
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    // A capture that arrives in the same cycle as flush is discarded.
    assign want_push = capture && accept && !flush;
    // While in ISSUE the FIFO is guaranteed to be non-empty. We only enter
    // ISSUE from IDLE with data queued, and nothing else pops in between.
    assign pop       = (state_reg == ISSUE) && !flush;
    // When the FIFO is full, a pop in the same cycle frees the slot first,
    // so the push is still accepted.
    assign push      = want_push && (!fifo_full || pop);
    assign drop      = want_push && !push;

    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || flush) begin
            overflow_reg <= 1'b0;
        end else if (drop) begin
            overflow_reg <= 1'b1;
        end
    end

    assign fifo_level = wr_ptr_reg - rd_ptr_reg;
    assign overflow   = overflow_reg;

    // -------------------------------------------------------------------------
    // FIFO storage. There is no reset on the storage array. The head entry is
    // read straight into the output registers while the FSM is in ISSUE.
    // -------------------------------------------------------------------------
    logic [9:0] fifo_mem [DEPTH];

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_idx] <= entry;
        end
    end

    // -------------------------------------------------------------------------
    // Held-key map (optional typematic filter)
    // -------------------------------------------------------------------------
`ifdef KEYSCHED_DEDUP_EN
    logic [511:0] held_map_reg;
    logic         key_held;

    assign key_held = held_map_reg[ps2_key[8:0]];
    // Make: queue only if the key is not already down.
    // Break: queue only if the key is currently down.
    assign accept   = ps2_key[9] ? !key_held : key_held;

    // Each map bit tracks its key from queued events only. An event that was
    // dropped on overflow leaves the map unchanged.
    genvar gi;
    generate
        for (gi = 0; gi < 512; gi++) begin : g_held
            always_ff @(posedge clk_sys) begin
                if (reset || flush) begin
                    held_map_reg[gi] <= 1'b0;
                end else if (push && (ps2_key[8:0] == 9'(gi))) begin
                    held_map_reg[gi] <= ps2_key[9];
                end
            end
        end
    endgenerate
`else
    assign accept = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Replay FSM, with registered outputs
    // -------------------------------------------------------------------------
    logic [CW-1:0] gap_cnt_reg;
    logic          key_ready_reg;
    logic          key_stroke_reg;
    logic [9:0]    key_code_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg      <= IDLE;
            gap_cnt_reg    <= '0;
            key_ready_reg  <= 1'b0;
            key_stroke_reg <= 1'b0;
            key_code_reg   <= '0;
        end else begin
            // key_ready is a single-cycle strobe. key_stroke and key_code keep
            // the last value that was issued.
            key_ready_reg <= 1'b0;
            if (flush) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (!fifo_empty) begin
                            state_reg <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        key_ready_reg  <= 1'b1;
                        key_stroke_reg <= fifo_mem[rd_idx][9];
                        key_code_reg   <= {1'b0, fifo_mem[rd_idx][8:0]};
                        gap_cnt_reg    <= CW'(GAP_CYCLES - 1);
                        state_reg      <= GAP;
                    end
                    GAP: begin
                        // Counting: GAP_CYCLES cycles in GAP, plus one in IDLE
                        // and one in ISSUE. So consecutive strobes are
                        // GAP_CYCLES+2 cycles apart.
                        if (gap_cnt_reg == '0) begin
                            state_reg <= IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg - 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign key_ready  = key_ready_reg;
    assign key_stroke = key_stroke_reg;
    assign key_code   = key_code_reg;

endmodule

// File: tb/tb_ps2_key_scheduler.sv
module tb_ps2_key_scheduler;

    localparam int DEPTH = 8;
    localparam int GAP   = 100;
`ifdef KEYSCHED_DEDUP_EN
    localparam int DEDUP_STROBES = 2;
`else
    localparam int DEDUP_STROBES = 5;
`endif

    logic        clk_sys;
    logic        reset;
    logic [10:0] ps2_key;
    logic        flush;
    logic        key_ready;
    logic        key_stroke;
    logic [9:0]  key_code;
    logic [3:0]  fifo_level;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int width_viol = 0;
    logic prev_ready = 1'b0;

    typedef struct {
        int         cyc;
        logic       stroke;
        logic [9:0] code;
    } strobe_t;
    strobe_t sq[$];

    ps2_key_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_key    (ps2_key),
        .flush      (flush),
        .key_ready  (key_ready),
        .key_stroke (key_stroke),
        .key_code   (key_code),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Record every strobe. Also flag any strobe that is more than one cycle wide.
    always @(negedge clk_sys) begin
        if (key_ready === 1'b1) begin
            sq.push_back('{cyc, key_stroke, key_code});
            $display("strobe cyc=%0d stroke=%0b code=%03h level=%0d", cyc, key_stroke, key_code, fifo_level);
            if (prev_ready) width_viol <= width_viol + 1;
        end
        prev_ready <= (key_ready === 1'b1);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic toggle(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        tick();
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int b = 0;
        while (sq.size() < n && b < budget) begin
            tick();
            b++;
        end
        checks++;
        if (sq.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: got %0d strobes, need %0d", tag, sq.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        ps2_key = 11'h000;
        idle(3);
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", key_ready); end
        checks++; if (key_stroke !== 1'b0) begin errors++; $display("FAIL reset_stroke: got %b want 0", key_stroke); end
        checks++; if (key_code !== 10'h000) begin errors++; $display("FAIL reset_code: got %03h want 000", key_code); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        // The toggle level changes while reset is held; this must not produce an event.
        ps2_key[10] = 1'b1;
        tick();
        reset = 1'b0;
        idle(20);
        checks++; if (sq.size() != 0) begin errors++; $display("FAIL reset_no_spurious: got %0d strobes want 0", sq.size()); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int k;
        sq.delete();
        k = cyc;
        toggle(1'b1, 1'b0, 8'h1C);
        wait_strobes(1, 20, "single");
        if (sq.size() >= 1) begin
            checks++; if (sq[0].cyc != k + 3) begin errors++; $display("FAIL single_latency: got cyc %0d want %0d", sq[0].cyc, k + 3); end
            checks++; if ({sq[0].stroke, sq[0].code} !== {1'b0, 10'h01C}) begin errors++; $display("FAIL single_data: got %b/%03h want 0/01C", sq[0].stroke, sq[0].code); end
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level: got %0d want 0", fifo_level); end
        idle(110);
        $display("test_single done");
    endtask

    task automatic test_burst();
        int k;
        logic [10:0] exp_d [3];
        exp_d[0] = {1'b0, 10'h01C};
        exp_d[1] = {1'b1, 10'h01C};
        exp_d[2] = {1'b0, 10'h175};
        sq.delete();
        k = cyc;
        toggle(1'b1, 1'b0, 8'h1C);
        toggle(1'b0, 1'b0, 8'h1C);
        toggle(1'b1, 1'b1, 8'h75);
        wait_strobes(3, 400, "burst");
        if (sq.size() >= 3) begin
            checks++; if (sq[0].cyc != k + 3) begin errors++; $display("FAIL burst_first: got cyc %0d want %0d", sq[0].cyc, k + 3); end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (sq[i].cyc - sq[i-1].cyc != GAP + 2) begin
                    errors++; $display("FAIL burst_spacing%0d: got %0d want %0d", i, sq[i].cyc - sq[i-1].cyc, GAP + 2);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if ({sq[i].stroke, sq[i].code} !== exp_d[i]) begin
                    errors++; $display("FAIL burst_data%0d: got %b/%03h want %b/%03h", i, sq[i].stroke, sq[i].code, exp_d[i][10], exp_d[i][9:0]);
                end
            end
        end
        idle(110);
        $display("test_burst done");
    endtask

    task automatic test_overflow();
        sq.delete();
        for (int i = 0; i < 11; i++) toggle(1'b1, 1'b0, 8'(8'h10 + i));
        checks++; if (sq.size() != 1) begin errors++; $display("FAIL ovf_issued: got %0d strobes want 1", sq.size()); end
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        wait_strobes(9, 1200, "ovf_drain");
        idle(110);
        checks++; if (sq.size() != 9) begin errors++; $display("FAIL ovf_total: got %0d strobes want 9", sq.size()); end
        if (sq.size() >= 9) begin
            checks++; if (sq[0].code !== 10'h010) begin errors++; $display("FAIL ovf_first: got %03h want 010", sq[0].code); end
            checks++; if (sq[1].code !== 10'h011) begin errors++; $display("FAIL ovf_second: got %03h want 011", sq[1].code); end
            checks++; if (sq[8].code !== 10'h018) begin errors++; $display("FAIL ovf_last: got %03h want 018", sq[8].code); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        $display("test_overflow done");
    endtask

    task automatic test_flush();
        int k;
        sq.delete();
        for (int i = 0; i < 6; i++) toggle(1'b1, 1'b0, 8'(8'h20 + i));
        checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL flush_pre_level: got %0d want 5", fifo_level); end
        // Flush, with a capture in the same cycle that must be discarded.
        flush = 1'b1;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h2F};
        tick();
        flush = 1'b0;
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL flush_level: got %0d want 0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow: got %b want 0", overflow); end
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", key_ready); end
        idle(10);
        checks++; if (sq.size() != 1) begin errors++; $display("FAIL flush_quiet: got %0d strobes want 1", sq.size()); end
        // The FSM must be back in IDLE even though the gap has not yet expired.
        k = cyc;
        toggle(1'b1, 1'b0, 8'h2E);
        wait_strobes(2, 20, "flush_next");
        if (sq.size() >= 2) begin
            checks++; if (sq[1].cyc != k + 3) begin errors++; $display("FAIL flush_next_latency: got cyc %0d want %0d", sq[1].cyc, k + 3); end
            checks++; if ({sq[1].stroke, sq[1].code} !== {1'b0, 10'h02E}) begin errors++; $display("FAIL flush_next_data: got %b/%03h want 0/02E", sq[1].stroke, sq[1].code); end
        end
        idle(110);
        $display("test_flush done");
    endtask

    task automatic test_reset_mid_gap();
        int k;
        sq.delete();
        for (int i = 0; i < 3; i++) toggle(1'b0, 1'b1, 8'(8'h30 + i));
        idle(2);
        checks++; if ({key_stroke, key_code} !== {1'b1, 10'h130}) begin errors++; $display("FAIL rst_pre_data: got %b/%03h want 1/130", key_stroke, key_code); end
        reset = 1'b1;
        ps2_key[10] = ~ps2_key[10];
        tick();
        checks++; if ({key_ready, key_stroke, key_code} !== 12'h000) begin errors++; $display("FAIL rst_outputs: got %b/%b/%03h want 0/0/000", key_ready, key_stroke, key_code); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        reset = 1'b0;
        idle(300);
        checks++; if (sq.size() != 1) begin errors++; $display("FAIL rst_lost: got %0d strobes want 1", sq.size()); end
        k = cyc;
        toggle(1'b1, 1'b0, 8'h22);
        wait_strobes(2, 20, "rst_next");
        if (sq.size() >= 2) begin
            checks++; if (sq[1].cyc != k + 3) begin errors++; $display("FAIL rst_next_latency: got cyc %0d want %0d", sq[1].cyc, k + 3); end
            checks++; if ({sq[1].stroke, sq[1].code} !== {1'b0, 10'h022}) begin errors++; $display("FAIL rst_next_data: got %b/%03h want 0/022", sq[1].stroke, sq[1].code); end
        end
        idle(110);
        $display("test_reset_mid_gap done");
    endtask

    task automatic test_dedup();
        sq.delete();
        toggle(1'b1, 1'b0, 8'h1C);
        toggle(1'b1, 1'b0, 8'h1C);
        toggle(1'b1, 1'b0, 8'h1C);
        toggle(1'b0, 1'b0, 8'h1C);
        toggle(1'b0, 1'b0, 8'h1C);
        wait_strobes(DEDUP_STROBES, 700, "dedup");
        idle(150);
        checks++; if (sq.size() != DEDUP_STROBES) begin errors++; $display("FAIL dedup_count: got %0d strobes want %0d", sq.size(), DEDUP_STROBES); end
        if (sq.size() >= DEDUP_STROBES) begin
            checks++; if ({sq[0].stroke, sq[0].code} !== {1'b0, 10'h01C}) begin errors++; $display("FAIL dedup_first: got %b/%03h want 0/01C", sq[0].stroke, sq[0].code); end
            checks++; if ({sq[DEDUP_STROBES-1].stroke, sq[DEDUP_STROBES-1].code} !== {1'b1, 10'h01C}) begin
                errors++; $display("FAIL dedup_last: got %b/%03h want 1/01C", sq[DEDUP_STROBES-1].stroke, sq[DEDUP_STROBES-1].code);
            end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dedup_overflow: got %b want 0", overflow); end
        $display("test_dedup done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_flush();
        test_reset_mid_gap();
        test_dedup();
        checks++;
        if (width_viol != 0) begin
            errors++;
            $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", width_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
